// File: rtl/lsnorm_cntl.sv
// Multi-cycle left-shift normalizer for the FPU add/subtract datapath.
// The mantissa is shifted left 8 bits per cycle while that is safe and 1 bit
// per cycle otherwise. Shifting stops when the leading one reaches the MSB or
// the exponent reaches 1. The LS-round increment is derived combinationally
// from the result and the captured sticky bit.
module lsnorm_cntl #(
    parameter int MW = 32,
    parameter int EW = 12,
    parameter int RP = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fpuhold,
    input  logic          start,
    input  logic [MW-1:0] man_in,
    input  logic [EW-1:0] exp_in,
    input  logic          sticky_in,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] man_out,
    output logic [EW-1:0] exp_out,
    output logic [7:0]    shcnt,
    output logic          zero,
    output logic          denorm,
    output logic          lsround
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [MW-1:0] man_reg, man_next;
    logic [EW-1:0] exp_reg, exp_next;
    logic [7:0]    shcnt_reg, shcnt_next;
    logic          sticky_reg, sticky_next;
    logic          zero_reg, zero_next;
    logic          denorm_reg, denorm_next;

    // Shift decisions for the current evaluation
    logic          man_is_zero;
    logic          coarse_ok;
    logic          fine_ok;
    logic [8:0]    shcnt_sum;
    logic [7:0]    shcnt_sat;

    assign man_is_zero = (man_reg == '0);
    assign coarse_ok   = (man_reg[MW-1 -: 8] == 8'd0) && (exp_reg > EW'(8));
    assign fine_ok     = !man_reg[MW-1] && (exp_reg > EW'(1));
    assign shcnt_sum   = {1'b0, shcnt_reg} + (coarse_ok ? 9'd8 : 9'd1);
    assign shcnt_sat   = shcnt_sum[8] ? 8'hFF : shcnt_sum[7:0];

    // Next-state and datapath update; every field holds unless changed below
    always_comb begin
        state_next  = state_reg;
        man_next    = man_reg;
        exp_next    = exp_reg;
        shcnt_next  = shcnt_reg;
        sticky_next = sticky_reg;
        zero_next   = zero_reg;
        denorm_next = denorm_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = SHIFT;
                    man_next    = man_in;
                    exp_next    = exp_in;
                    shcnt_next  = 8'd0;
                    sticky_next = sticky_in;
                    zero_next   = 1'b0;
                    denorm_next = 1'b0;
                end
            end
            SHIFT: begin
                if (man_is_zero) begin
                    zero_next  = 1'b1;
                    exp_next   = '0;
                    state_next = DONE;
                end else if (coarse_ok) begin
                    man_next   = man_reg << 8;
                    exp_next   = exp_reg - EW'(8);
                    shcnt_next = shcnt_sat;
                end else if (fine_ok) begin
                    man_next   = man_reg << 1;
                    exp_next   = exp_reg - EW'(1);
                    shcnt_next = shcnt_sat;
                end else begin
                    // Stopped with MSB clear means the exponent floor was hit
                    denorm_next = ~man_reg[MW-1];
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers; hold freezes everything, reset wins over hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            man_reg    <= '0;
            exp_reg    <= '0;
            shcnt_reg  <= 8'd0;
            sticky_reg <= 1'b0;
            zero_reg   <= 1'b0;
            denorm_reg <= 1'b0;
        end else if (!fpuhold) begin
            state_reg  <= state_next;
            man_reg    <= man_next;
            exp_reg    <= exp_next;
            shcnt_reg  <= shcnt_next;
            sticky_reg <= sticky_next;
            zero_reg   <= zero_next;
            denorm_reg <= denorm_next;
        end
    end

    // Round-to-nearest-even increment at result bit RP
    logic round_l, round_g, round_s;
    assign round_l = man_reg[RP];
    assign round_g = man_reg[RP-1];
    assign round_s = (|man_reg[RP-2:0]) | sticky_reg;

    assign lsround = round_g & (round_s | round_l);
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign man_out = man_reg;
    assign exp_out = exp_reg;
    assign shcnt   = shcnt_reg;
    assign zero    = zero_reg;
    assign denorm  = denorm_reg;

endmodule

// File: doc/lsnorm_cntl.md
Name: lsnorm_cntl

Overview:
Multi-cycle left-shift normalizer and LS-round generator for the FPU add/subtract datapath.
- Takes the post-add mantissa, exponent and incoming sticky.
- Shifts the mantissa left (coarse 8-bit or fine 1-bit per cycle) until the leading one reaches the MSB or the exponent reaches the minimum normal value.
- Reports the shift count, zero/denormal flags and the lsround bit consumed by the incin decode.

Parameters:
MW, 32, mantissa width (>= 16)
EW, 12, exponent width
RP, 8, LSB position of the rounded result (L = bit RP, G = bit RP-1, S = OR of bits RP-2..0 and sticky)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
fpuhold  input  1  freezes all state, outputs held
start  input  1  request; accepted only in IDLE with fpuhold=0
man_in  input  MW  unnormalized mantissa, sampled on accept
exp_in  input  EW  unsigned biased exponent, sampled on accept
sticky_in  input  1  sticky from alignment, sampled on accept
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle completion pulse
man_out  output  MW  normalized mantissa
exp_out  output  EW  adjusted exponent
shcnt  output  8  total left-shift amount
zero  output  1  mantissa was zero
denorm  output  1  stopped at exp=1 with man_out[MW-1]=0, man nonzero
lsround  output  1  round-to-nearest-even increment for man_out

Behaviour:
- Reset: state=IDLE; busy=0, done=0, man_out=0, exp_out=0, shcnt=0, zero=0, denorm=0, lsround=0. Reset overrides fpuhold and aborts any operation in progress; no done is issued.
- fpuhold=1: no register changes at all, including state, done and outputs. A start presented during hold is not accepted.
- IDLE:
  - On start, load man_out<=man_in, exp_out<=exp_in, shcnt<=0, captured sticky<=sticky_in; clear zero and denorm; go to SHIFT.
  - A start while not in IDLE is ignored.
- SHIFT: one evaluation per cycle, in priority order:
  1. man_out==0: zero<=1, exp_out<=0, go to DONE.
  2. man_out[MW-1:MW-8]==0 and exp_out>8: man_out<<=8, exp_out-=8, shcnt+=8.
  3. man_out[MW-1]==0 and exp_out>1: man_out<<=1, exp_out-=1, shcnt+=1.
  4. Otherwise: denorm<=~man_out[MW-1], go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. Outputs stay held until the next accepted start.
- Latency: start accepted at cycle 0; N shift cycles; terminating evaluation at cycle N+1; done at cycle N+2. Minimum latency is 2.
- lsround (combinational from the registered man_out and sticky):
  - L = man_out[RP], G = man_out[RP-1], S = |man_out[RP-2:0] | sticky.
  - lsround = G & (S | L).
  - Valid whenever done=1.
- Bits shifted in at the LSB are 0. shcnt saturates at 255; it never exceeds MW in practice.
- exp_in<=1 with a nonzero mantissa and MSB clear: no shift, denorm=1.
- exp_in 2..8: only fine shifts are used.

Test Plan:
1. man_in=0x80000000, exp_in=100, sticky_in=0 -> done at cycle 2, man_out=0x80000000, exp_out=100, shcnt=0, zero=0, denorm=0, lsround=0.
2. man_in=0x00000001, exp_in=100 -> 3 coarse + 7 fine shifts, done at cycle 12, man_out=0x80000000, exp_out=69, shcnt=31, denorm=0.
3. man_in=0x00010000, exp_in=5 -> 4 fine shifts, done at cycle 6, man_out=0x00100000, exp_out=1, shcnt=4, denorm=1.
4. man_in=0 -> done at cycle 2, zero=1, exp_out=0, shcnt=0, denorm=0.
5. Rounding, one case per start:
   - man_in=0x80000180, sticky 0 -> lsround=1.
   - man_in=0x80000080, sticky 0 -> lsround=0.
   - man_in=0x80000080, sticky 1 -> lsround=1.
6. Control edge cases:
   - Start case 2, hold fpuhold=1 for 5 cycles mid-shift -> done delayed by exactly 5 cycles, identical results.
   - A second start while busy is ignored.
   - reset asserted mid-SHIFT -> next cycle busy=0, all outputs 0, no done.
